// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks BOOT -> FETCH -> ISSUE, computes the next PC
// (sequential or branch target) and traps into a sticky ERROR on a fetch timeout.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        stall,
    input  logic        branchFlag,
    input  logic        unconditionalBranchFlag,
    input  logic        zeroFlag,
    input  logic [31:0] branchOffset,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic [31:0] instruction,
    output logic        instrValid,
    output logic [31:0] pcOut,
    output logic [31:0] retiredCount,
    output logic        fetchError
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    localparam logic [31:0] PC_RESET = {RESET_VECTOR[31:2], 2'b00};

    // Wide enough to hold TIMEOUT_CYCLES itself, so the limit is always reachable.
    localparam int unsigned       WAIT_W     = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    state_e            state_q,   state_d;
    logic [31:0]       pc_q,      pc_d;
    logic [31:0]       instr_q,   instr_d;
    logic [31:0]       retired_q, retired_d;
    logic [WAIT_W-1:0] wait_q,    wait_d;
    logic              error_q,   error_d;

    logic              taken;
    logic [WAIT_W-1:0] wait_inc;
    logic [31:0]       branch_target;
    logic [31:0]       seq_target;

    assign wait_inc      = wait_q + WAIT_ONE;
    assign branch_target = pc_q + (branchOffset << 2);
    assign seq_target    = pc_q + 32'd4;

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        wait_d    = wait_q;
        error_d   = error_q;
        taken     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                wait_d  = '0;
            end

            ST_FETCH: begin
                // Ready wins over a timeout landing in the same cycle.
                if (imemReady) begin
                    instr_d = imemData;
                    state_d = ST_ISSUE;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_inc == WAIT_LIMIT)) begin
                    wait_d  = wait_inc;
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    wait_d = wait_inc;
                end
            end

            ST_ISSUE: begin
                if (!stall) begin
                    taken     = (zeroFlag && branchFlag) || unconditionalBranchFlag;
                    pc_d      = taken ? branch_target : seq_target;
                    retired_d = retired_q + 32'd1;
                    wait_d    = '0;
                    state_d   = ST_FETCH;
                end
            end

            ST_ERROR: begin
                error_d = 1'b1;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_BOOT;
            pc_q      <= PC_RESET;
            instr_q   <= '0;
            retired_q <= '0;
            wait_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
            error_q   <= error_d;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free.
    assign imemReq      = (state_q == ST_FETCH);
    assign instrValid   = (state_q == ST_ISSUE);
    assign imemAddr     = pc_q;
    assign pcOut        = pc_q;
    assign instruction  = instr_q;
    assign retiredCount = retired_q;
    assign fetchError   = error_q;

    a_req_valid_exclusive: assert property (
        @(posedge clock) disable iff (!resetN) !(imemReq && instrValid));

    a_error_sticky: assert property (
        @(posedge clock) disable iff (!resetN) fetchError |=> fetchError);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table of per-instruction vectors plus
// hand-written reset, timeout and PC wrap-around sequences.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        resetN;
    logic        stall;
    logic        branchFlag;
    logic        unconditionalBranchFlag;
    logic        zeroFlag;
    logic [31:0] branchOffset;
    logic        imemReady;
    logic [31:0] imemData;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] instruction;
    logic        instrValid;
    logic [31:0] pcOut;
    logic [31:0] retiredCount;
    logic        fetchError;

    logic        rst2_n;
    logic        stall2  = 1'b0;
    logic        br2     = 1'b0;
    logic        ubr2    = 1'b0;
    logic        zero2   = 1'b0;
    logic [31:0] off2    = 32'd0;
    logic        ready2  = 1'b1;
    logic [31:0] data2   = 32'hDEAD_0002;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] retired2;
    logic        err2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock                  (clock),
        .resetN                 (resetN),
        .stall                  (stall),
        .branchFlag             (branchFlag),
        .unconditionalBranchFlag(unconditionalBranchFlag),
        .zeroFlag               (zeroFlag),
        .branchOffset           (branchOffset),
        .imemReady              (imemReady),
        .imemData               (imemData),
        .imemReq                (imemReq),
        .imemAddr               (imemAddr),
        .instruction            (instruction),
        .instrValid             (instrValid),
        .pcOut                  (pcOut),
        .retiredCount           (retiredCount),
        .fetchError             (fetchError)
    );

    fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .clock                  (clock),
        .resetN                 (rst2_n),
        .stall                  (stall2),
        .branchFlag             (br2),
        .unconditionalBranchFlag(ubr2),
        .zeroFlag               (zero2),
        .branchOffset           (off2),
        .imemReady              (ready2),
        .imemData               (data2),
        .imemReq                (req2),
        .imemAddr               (addr2),
        .instruction            (instr2),
        .instrValid             (valid2),
        .pcOut                  (pc2),
        .retiredCount           (retired2),
        .fetchError             (err2)
    );

    typedef struct {
        logic [31:0] data;
        int          wait_cycles;
        int          stall_cycles;
        logic        br;
        logic        ubr;
        logic        zero;
        logic [31:0] off;
        logic [31:0] exp_next;
        logic [31:0] exp_retired;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] exp_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        stall                   = 1'b0;
        branchFlag              = 1'b0;
        unconditionalBranchFlag = 1'b0;
        zeroFlag                = 1'b0;
        branchOffset            = 32'd0;
        imemReady               = 1'b0;
        imemData                = 32'd0;
    endtask

    // Entered at a negedge with the DUT in FETCH at exp_pc; leaves it in FETCH at v.exp_next.
    task automatic apply_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, " fetch_addr"}, imemAddr, exp_pc);
        check({tag, " fetch_req"}, {31'd0, imemReq}, 32'd1);
        for (int w = 0; w < v.wait_cycles; w++) begin
            imemReady               = 1'b0;
            stall                   = 1'b1;
            branchFlag              = 1'b1;
            unconditionalBranchFlag = 1'b1;
            zeroFlag                = 1'b1;
            branchOffset            = 32'h0000_0100;
            tick();
            check({tag, " wait_addr"}, imemAddr, exp_pc);
            check({tag, " wait_req"}, {31'd0, imemReq}, 32'd1);
        end
        imemReady = 1'b1;
        imemData  = v.data;
        tick();
        imemReady = 1'b0;
        imemData  = 32'hBAD0_BAD0;
        check({tag, " issue_valid"}, {31'd0, instrValid}, 32'd1);
        check({tag, " issue_req"}, {31'd0, imemReq}, 32'd0);
        check({tag, " issue_instr"}, instruction, v.data);
        check({tag, " issue_pc"}, pcOut, exp_pc);
        stall                   = (v.stall_cycles > 0);
        branchFlag              = v.br;
        unconditionalBranchFlag = v.ubr;
        zeroFlag                = v.zero;
        branchOffset            = v.off;
        for (int s = 0; s < v.stall_cycles; s++) begin
            tick();
            check({tag, " stall_pc"}, pcOut, exp_pc);
            check({tag, " stall_valid"}, {31'd0, instrValid}, 32'd1);
            check({tag, " stall_retired"}, retiredCount, v.exp_retired - 32'd1);
        end
        stall = 1'b0;
        tick();
        check({tag, " next_addr"}, imemAddr, v.exp_next);
        check({tag, " next_valid"}, {31'd0, instrValid}, 32'd0);
        check({tag, " retired"}, retiredCount, v.exp_retired);
        clear_inputs();
        exp_pc = v.exp_next;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           data          wait stall br    ubr   zero  offset         next           retired
        vecs[0]  = '{32'h1111_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0,        32'h0000_0004, 32'd1};
        vecs[1]  = '{32'h2222_0002, 0, 0, 1'b0, 1'b0, 1'b1, 32'd7,        32'h0000_0008, 32'd2};
        vecs[2]  = '{32'h3333_0003, 2, 0, 1'b0, 1'b0, 1'b0, 32'd0,        32'h0000_000C, 32'd3};
        vecs[3]  = '{32'h4444_0004, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0,        32'h0000_0010, 32'd4};
        vecs[4]  = '{32'h5555_0005, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0008, 32'd5};
        vecs[5]  = '{32'h6666_0006, 0, 0, 1'b0, 1'b1, 1'b0, 32'd2,        32'h0000_0010, 32'd6};
        vecs[6]  = '{32'h7777_0007, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0014, 32'd7};
        vecs[7]  = '{32'h8888_0008, 1, 0, 1'b1, 1'b1, 1'b0, 32'd3,        32'h0000_0020, 32'd8};
        vecs[8]  = '{32'h9999_0009, 0, 3, 1'b0, 1'b1, 1'b0, 32'd5,        32'h0000_0034, 32'd9};
        vecs[9]  = '{32'hAAAA_000A, 0, 1, 1'b1, 1'b0, 1'b1, 32'h4000_0001, 32'h0000_0038, 32'd10};
        vecs[10] = '{32'hBBBB_000B, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF2, 32'h0000_0000, 32'd11};
        vecs[11] = '{32'hCCCC_000C, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0,        32'h0000_0004, 32'd12};

        clear_inputs();
        resetN = 1'b0;
        rst2_n = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state and BOOT.
        resetN = 1'b1;
        check("boot_req", {31'd0, imemReq}, 32'd0);
        check("boot_valid", {31'd0, instrValid}, 32'd0);
        check("boot_pc", pcOut, 32'd0);
        check("boot_instr", instruction, 32'd0);
        check("boot_retired", retiredCount, 32'd0);
        check("boot_error", {31'd0, fetchError}, 32'd0);
        tick();
        check("first_fetch_req", {31'd0, imemReq}, 32'd1);
        check("first_fetch_addr", imemAddr, 32'd0);

        // Asynchronous reset between edges while in FETCH.
        #2 resetN = 1'b0;
        #1;
        check("rst_fetch_req", {31'd0, imemReq}, 32'd0);
        check("rst_fetch_valid", {31'd0, instrValid}, 32'd0);
        check("rst_fetch_retired", retiredCount, 32'd0);
        check("rst_fetch_pc", pcOut, 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        tick();
        imemReady = 1'b1;
        imemData  = 32'h0F0F_0F0F;
        tick();
        imemReady = 1'b0;
        check("pre_rst_issue_valid", {31'd0, instrValid}, 32'd1);

        // Asynchronous reset while in ISSUE: no retire.
        #2 resetN = 1'b0;
        #1;
        check("rst_issue_valid", {31'd0, instrValid}, 32'd0);
        check("rst_issue_instr", instruction, 32'd0);
        check("rst_issue_retired", retiredCount, 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        tick();
        check("post_rst_retired", retiredCount, 32'd0);

        exp_pc = 32'd0;
        for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

        // Ready arriving on the 16th wait cycle still issues normally.
        imemReady = 1'b0;
        repeat (15) tick();
        check("to_late_req", {31'd0, imemReq}, 32'd1);
        check("to_late_error", {31'd0, fetchError}, 32'd0);
        imemReady = 1'b1;
        imemData  = 32'h1234_5678;
        tick();
        imemReady = 1'b0;
        check("to_late_valid", {31'd0, instrValid}, 32'd1);
        check("to_late_instr", instruction, 32'h1234_5678);
        check("to_late_error2", {31'd0, fetchError}, 32'd0);
        tick();
        check("to_late_next_addr", imemAddr, 32'h0000_0008);
        check("to_late_retired", retiredCount, 32'd13);

        // Sixteen idle FETCH cycles trip the timeout.
        repeat (15) tick();
        check("to_15_req", {31'd0, imemReq}, 32'd1);
        check("to_15_error", {31'd0, fetchError}, 32'd0);
        tick();
        check("to_error", {31'd0, fetchError}, 32'd1);
        check("to_error_req", {31'd0, imemReq}, 32'd0);
        check("to_error_valid", {31'd0, instrValid}, 32'd0);
        imemReady = 1'b1;
        repeat (3) tick();
        imemReady = 1'b0;
        check("to_sticky_error", {31'd0, fetchError}, 32'd1);
        check("to_sticky_valid", {31'd0, instrValid}, 32'd0);
        check("to_sticky_retired", retiredCount, 32'd13);

        #2 resetN = 1'b0;
        #1;
        check("rst_error_clear", {31'd0, fetchError}, 32'd0);
        @(negedge clock);
        resetN = 1'b1;

        // PC wrap-around from the top of the address space.
        rst2_n = 1'b1;
        check("wrap_boot_pc", pc2, 32'hFFFF_FFFC);
        tick();
        check("wrap_fetch0_addr", addr2, 32'hFFFF_FFFC);
        tick();
        check("wrap_issue_valid", {31'd0, valid2}, 32'd1);
        tick();
        check("wrap_fetch1_addr", addr2, 32'h0000_0000);
        check("wrap_fetch1_req", {31'd0, req2}, 32'd1);
        check("wrap_retired", retired2, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address; bits [1:0] are forced to 0.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum FETCH wait cycles before error; 0 disables the timeout.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, datapath hold request.
REQ-006 SHALL have port branchFlag, input, 1, conditional branch decoded.
REQ-007 SHALL have port unconditionalBranchFlag, input, 1, unconditional branch decoded.
REQ-008 SHALL have port zeroFlag, input, 1, ALU zero result.
REQ-009 SHALL have port branchOffset, input, 32, signed word offset (two's complement).
REQ-010 SHALL have port imemReady, input, 1, instruction memory data valid.
REQ-011 SHALL have port imemData, input, 32, instruction memory read data.
REQ-012 SHALL have port imemReq, output, 1, fetch request.
REQ-013 SHALL have port imemAddr, output, 32, fetch address (equals pcOut).
REQ-014 SHALL have port instruction, output, 32, latched instruction.
REQ-015 SHALL have port instrValid, output, 1, instruction valid to the datapath.
REQ-016 SHALL have port pcOut, output, 32, address of the current instruction.
REQ-017 SHALL have port retiredCount, output, 32, count of instructions issued.
REQ-018 SHALL have port fetchError, output, 1, sticky timeout indicator.

Function
REQ-019 SHALL implement the FSM states BOOT, FETCH, ISSUE and ERROR, all registered.
REQ-020 BOOT SHALL hold imemReq=0 and instrValid=0 for one cycle, then go to FETCH.
REQ-021 FETCH SHALL drive imemReq=1 and hold imemAddr=pcOut stable until imemReady=1.
REQ-022 When imemReady=1 in FETCH, the block SHALL latch imemData into instruction, set instrValid=1 on the next cycle and enter ISSUE (1-cycle latency from ready to valid).
REQ-023 ISSUE SHALL drive imemReq=0 and instrValid=1.
REQ-024 In ISSUE with stall=1, the block SHALL hold state, pcOut, instruction and retiredCount unchanged.
REQ-025 In ISSUE with stall=0, the block SHALL compute taken = (zeroFlag AND branchFlag) OR unconditionalBranchFlag.
REQ-026 When taken, the next pcOut SHALL be pcOut + (branchOffset << 2); otherwise pcOut + 4.
REQ-027 On leaving ISSUE, the block SHALL increment retiredCount, clear instrValid and enter FETCH.
REQ-028 All PC arithmetic SHALL be modulo 2^32: wrap-around is silent, and shifted-out offset bits are discarded.
REQ-029 Branch and stall inputs SHALL be ignored outside ISSUE.
REQ-030 retiredCount SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 waitCount (internal) SHALL reset to 0 on FETCH entry and increment each FETCH cycle with imemReady=0.
REQ-032 When TIMEOUT_CYCLES>0 and waitCount reaches TIMEOUT_CYCLES, the block SHALL enter ERROR.
REQ-033 ERROR SHALL set fetchError=1, imemReq=0 and instrValid=0, and remain until reset.
REQ-034 If imemReady=1 in the same cycle waitCount reaches TIMEOUT_CYCLES, the ready SHALL win (normal ISSUE).
REQ-035 imemReady SHALL be ignored outside FETCH.

Reset
REQ-036 resetN=0 SHALL asynchronously force state=BOOT, pcOut=RESET_VECTOR, instruction=0, instrValid=0, imemReq=0, retiredCount=0, fetchError=0 and waitCount=0.
REQ-037 A reset asserted mid-FETCH or mid-ISSUE SHALL abort that operation with no retire increment.
REQ-038 After release, the first imemReq=1 SHALL occur on the second rising edge (BOOT then FETCH).

Verification
REQ-039 Sequential fetch: imemReady=1 every request, no branches -> imemAddr 0x0, 0x4, 0x8; retiredCount=3 after 3 issues; each instruction appears one cycle after its ready.
REQ-040 Taken conditional branch: pcOut=0x10, branchFlag=1, zeroFlag=1, branchOffset=-2 -> next imemAddr=0x08; with zeroFlag=0 -> next imemAddr=0x14.
REQ-041 Stall: stall=1 for 3 ISSUE cycles with unconditionalBranchFlag=1 and offset=5 at pcOut=0x20 -> pcOut held at 0x20 and instrValid=1 throughout; after release, next imemAddr=0x34.
REQ-042 Wrap-around: RESET_VECTOR=32'hFFFF_FFFC, no branch -> second fetch address 0x0.
REQ-043 Timeout: imemReady=0 for 16 cycles -> fetchError=1 and imemReq=0; ready arriving on cycle 16 instead -> no error.
REQ-044 Async reset mid-FETCH: resetN low between edges -> outputs at reset values immediately; retiredCount unchanged from 0.
